// File: rtl/bnn_xnor_act.sv
// bnn_xnor_act
// Binary neural-network neuron engine. For each output neuron, it accumulates
// the XNOR popcount of streamed activation/weight beats. On the final beat it
// emits the sign activation (acc >= threshold) as a one-bit write into a
// downstream max-pool buffer. After NUM_OUT neurons it pulses oDONE and returns
// to idle.
//
// Ports
//   iCLK      clock, all state updates on posedge
//   iRST      asynchronous active-high reset
//   iSTART    frame start pulse, honoured only while idle
//   iTHRESH   activation threshold, latched on an accepted iSTART
//   iVALID    input beat valid
//   iLAST     final beat of the current neuron (qualified by iVALID)
//   iDATA     binary activations (1 = +1, 0 = -1)
//   iWEIGHT   binary weights, same encoding
//   oREADY    beats are accepted when iVALID & oREADY
//   oDATA     sign activation of the finished neuron, 0 outside strobes
//   oADDR     neuron index of the last emitted result
//   oWriteEN  one-cycle write strobe for oDATA/oADDR
//   oDONE     one-cycle pulse after the final neuron of a frame
module bnn_xnor_act #(
  parameter int IN_W    = 8,
  parameter int ACC_W   = 8,
  parameter int NUM_OUT = 100
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iSTART,
  input  logic [ACC_W-1:0] iTHRESH,
  input  logic             iVALID,
  input  logic             iLAST,
  input  logic [IN_W-1:0]  iDATA,
  input  logic [IN_W-1:0]  iWEIGHT,
  output logic             oREADY,
  output logic             oDATA,
  output logic [6:0]       oADDR,
  output logic             oWriteEN,
  output logic             oDONE
);

  localparam int PC_W  = $clog2(IN_W + 1);
  localparam int SUM_W = ((ACC_W > PC_W) ? ACC_W : PC_W) + 1;
  localparam logic [6:0] LAST_IDX = 7'(NUM_OUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_EMIT} state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] thresh_q;
  logic [6:0]       cnt_q;
  logic [6:0]       addr_q;
  logic             wen_q;
  logic             data_q;
  logic             done_q;
  logic [ACC_W-1:0] acc_d;

  // Count of matching bit positions (XNOR = 1 where activation equals weight).
  function automatic logic [PC_W-1:0] popcnt(input logic [IN_W-1:0] x);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < IN_W; i++) begin
      c = c + PC_W'(x[i]);
    end
    return c;
  endfunction

  // Accumulator add that clamps at all-ones instead of wrapping.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({ACC_W{1'b1}})) begin
      return {ACC_W{1'b1}};
    end
    return s[ACC_W-1:0];
  endfunction

  assign acc_d = sat_add(acc_q, popcnt(~(iDATA ^ iWEIGHT)));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      thresh_q <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      data_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // Strobes default low; each is raised for exactly one cycle below.
      wen_q  <= 1'b0;
      data_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (iSTART) begin
            thresh_q <= iTHRESH;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (iVALID) begin
            acc_q <= acc_d;
            if (iLAST) begin
              // Decide on the updated sum so the final beat counts.
              wen_q   <= 1'b1;
              data_q  <= (acc_d >= thresh_q);
              addr_q  <= cnt_q;
              state_q <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          acc_q <= '0;
          if (cnt_q == LAST_IDX) begin
            cnt_q   <= '0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q   <= cnt_q + 7'd1;
            state_q <= ST_ACC;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign oREADY   = (state_q == ST_ACC);
  assign oDATA    = data_q;
  assign oADDR    = addr_q;
  assign oWriteEN = wen_q;
  assign oDONE    = done_q;

endmodule

// File: doc/bnn_xnor_act.md
BNN_XNOR_ACT -- requirements
Module: bnn_xnor_act

Interface
REQ-001 Parameter IN_W, default 8: bits of activation/weight per input beat.
REQ-002 Parameter ACC_W, default 8: popcount accumulator width.
REQ-003 Parameter NUM_OUT, default 100: output neurons per frame, range 1..128.
REQ-004 iCLK  input  1  sole clock; all state updates on posedge.
REQ-005 iRST  input  1  reset, asynchronous, active-high.
REQ-006 iSTART  input  1  frame start pulse; honoured only in IDLE.
REQ-007 iTHRESH  input  ACC_W  activation threshold; sampled on accepted iSTART.
REQ-008 iVALID  input  1  input beat valid.
REQ-009 iLAST  input  1  marks final beat of current neuron; qualified by iVALID.
REQ-010 iDATA  input  IN_W  binary input activations, bit 1 means +1, bit 0 means -1.
REQ-011 iWEIGHT  input  IN_W  binary weights, same encoding.
REQ-012 oREADY  output  1  high only in ACC; beats accepted when iVALID&oREADY.
REQ-013 oDATA  output  1  sign activation of finished neuron; 0 whenever oWriteEN low.
REQ-014 oADDR  output  7  neuron index for the downstream max-pool write port.
REQ-015 oWriteEN  output  1  one-cycle write strobe for oDATA/oADDR.
REQ-016 oDONE  output  1  one-cycle pulse after final neuron of frame.

Function
REQ-017 FSM states: IDLE, ACC, EMIT; one-hot or binary encoding free.
REQ-018 IDLE: iSTART=1 -> latch iTHRESH, clear accumulator, clear neuron counter, go ACC next cycle.
REQ-019 ACC, accepted beat: acc <= acc + popcount(~(iDATA ^ iWEIGHT)), computed over all IN_W bits.
REQ-020 Accumulator saturates at 2^ACC_W-1; no wrap.
REQ-021 ACC, accepted beat with iLAST=1 -> go EMIT; that beat's popcount included in acc.
REQ-022 ACC, iVALID=0 -> hold all state; no timeout.
REQ-023 EMIT lasts exactly one cycle: oWriteEN=1, oDATA=(acc >= latched threshold), oADDR=neuron counter.
REQ-024 Latency: iLAST beat accepted at edge N -> oWriteEN high in cycle after edge N (1 cycle).
REQ-025 EMIT with counter < NUM_OUT-1 -> counter+1, acc cleared, return ACC.
REQ-026 EMIT with counter = NUM_OUT-1 -> counter wraps to 0, oDONE=1 in following cycle (IDLE), go IDLE.
REQ-027 iVALID, iLAST, iDATA ignored outside ACC (oREADY=0); no beat lost is guaranteed only if source obeys oREADY.
REQ-028 iSTART ignored in ACC and EMIT; threshold not re-latched mid-frame.
REQ-029 iSTART in IDLE same cycle as oDONE pulse accepted normally (back-to-back frames).
REQ-030 oADDR holds last emitted index between strobes; strictly increasing 0..NUM_OUT-1 within a frame.
REQ-031 Output oDATA/oADDR/oWriteEN format matches max-pool write port: one bit per address, one strobe per address.

Reset
REQ-032 iRST=1 asynchronously forces IDLE, acc=0, counter=0, threshold=0.
REQ-033 Reset values: oREADY=0, oDATA=0, oADDR=0, oWriteEN=0, oDONE=0.
REQ-034 iRST asserted mid-frame (ACC or EMIT) aborts frame; no oWriteEN or oDONE until a new iSTART after release.
REQ-035 First iSTART accepted on first rising edge with iRST low.

Verification
REQ-036 NUM_OUT=1, iTHRESH=16, beats iDATA=FF/iWEIGHT=FF x2 (last on 2nd) -> acc 16, oWriteEN 1 cycle later, oDATA=1, oADDR=0, oDONE next cycle.
REQ-037 Same with iTHRESH=17 -> oDATA=0; iDATA=00/iWEIGHT=FF single last beat, iTHRESH=1 -> popcount 0, oDATA=0.
REQ-038 ACC_W=4, five beats FF/FF, iTHRESH=15 -> acc saturates at 15, oDATA=1.
REQ-039 NUM_OUT=3, one beat per neuron with idle gaps on iVALID -> oADDR 0,1,2 with three single-cycle strobes, oDONE once, then IDLE; second iSTART restarts at oADDR=0.
REQ-040 iRST pulsed during ACC of neuron 1 -> all outputs 0 immediately, no strobe; iVALID beats while IDLE ignored; iSTART in ACC with new iTHRESH -> old threshold still used.
